// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the div_sequencer slice.
//   state_t   - controller FSM states
//   OP_*      - req_op encodings (bit1 = remainder, bit0 = signed)
//   XLEN_DEF  - default operand width
package div_pkg;
  localparam int XLEN_DEF = 64;

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  localparam logic [1:0] OP_DIVU = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;
endpackage

// File: rtl/div_sequencer_if.sv
// div_sequencer_if: request/response handshake bundle for the divider.
//   req_*  : requester -> divider (valid/ready, op, dividend, divisor)
//   resp_* : divider -> consumer (valid/ready, result, divide-by-zero flag)
//   master : requester/consumer side, slave : divider side
interface div_sequencer_if #(parameter int XLEN = div_pkg::XLEN_DEF);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;
  logic            resp_dbz;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_dbz
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_dbz
  );
endinterface

// File: rtl/div_sequencer_sub.sv
// div_sequencer_sub: W-bit subtractor, diff = a - b (mod 2^W), borrow = (a < b).
//   a, b   : operands
//   diff   : difference
//   borrow : 1 when a < b (unsigned)
module div_sequencer_sub #(parameter int W = div_pkg::XLEN_DEF) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);
  logic [W:0] full;

  assign full   = {1'b0, a} - {1'b0, b};
  assign diff   = full[W-1:0];
  assign borrow = full[W];
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divider controller (RV64M DIV/DIVU/REM/REMU).
//   clk, rst_n : clock, async active-low reset
//   bus        : div_sequencer_if.slave request/response handshake
//   busy       : high whenever the FSM is not IDLE (pipeline stall)
// One trial subtraction per cycle on a single shared subtractor; XLEN iterations.
// Build option: DIV_SIGNED_EN enables signed ops (magnitude prep, overflow
// short-cut, result negation). Without it req_op[0] is ignored.
module div_sequencer
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  div_sequencer_if.slave  bus,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_t          state, state_nx;
  logic [XLEN-1:0] a_r, b_r, r_q, q_q, res_r;
  logic [CW-1:0]   cnt;
  logic            rem_r, dbz_r;
  logic            ovf;

  // Trial subtraction: shift one dividend bit into the partial remainder.
  logic [XLEN-1:0] s, diff;
  logic            borrow, take;

  assign s = {r_q[XLEN-2:0], q_q[XLEN-1]};

  div_sequencer_sub #(.W(XLEN)) u_sub (
    .a      (s),
    .b      (b_r),
    .diff   (diff),
    .borrow (borrow)
  );

  // R[XLEN-1] set means the shifted value is >= 2^XLEN > |b|: always take.
  assign take = r_q[XLEN-1] | ~borrow;

`ifdef DIV_SIGNED_EN
  logic sgn_r, q_neg, r_neg;
  assign ovf = sgn_r && (a_r == {1'b1, {(XLEN-1){1'b0}}}) && (&b_r);
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.req_valid)             state_nx = PREP;
      PREP: if (b_r == '0 || ovf)          state_nx = DONE;
            else                           state_nx = RUN;
      RUN:  if (cnt == LAST)               state_nx = FIX;
      FIX:                                 state_nx = DONE;
      DONE: if (bus.resp_ready)            state_nx = IDLE;
      default:                             state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      r_q   <= '0;
      q_q   <= '0;
      res_r <= '0;
      cnt   <= '0;
      rem_r <= 1'b0;
      dbz_r <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_r <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          a_r   <= bus.req_a;
          b_r   <= bus.req_b;
          rem_r <= bus.req_op[1];
`ifdef DIV_SIGNED_EN
          sgn_r <= bus.req_op[0];
`endif
        end
        PREP: begin
          if (b_r == '0) begin
            res_r <= rem_r ? a_r : '1;
            dbz_r <= 1'b1;
          end else if (ovf) begin
            res_r <= rem_r ? '0 : a_r;
            dbz_r <= 1'b0;
          end else begin
            dbz_r <= 1'b0;
            r_q   <= '0;
            cnt   <= '0;
`ifdef DIV_SIGNED_EN
            q_q   <= (sgn_r && a_r[XLEN-1]) ? -a_r : a_r;
            b_r   <= (sgn_r && b_r[XLEN-1]) ? -b_r : b_r;
            q_neg <= sgn_r & (a_r[XLEN-1] ^ b_r[XLEN-1]);
            r_neg <= sgn_r & a_r[XLEN-1];
`else
            q_q   <= a_r;
`endif
          end
        end
        RUN: begin
          r_q <= take ? diff : s;
          q_q <= {q_q[XLEN-2:0], take};
          // Hold on the last iteration so the counter never wraps.
          if (cnt != LAST) cnt <= cnt + 1'b1;
        end
        FIX: begin
`ifdef DIV_SIGNED_EN
          res_r <= rem_r ? (r_neg ? -r_q : r_q) : (q_neg ? -q_q : q_q);
`else
          res_r <= rem_r ? r_q : q_q;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.resp_valid  = (state == DONE);
  assign bus.resp_result = res_r;
  assign bus.resp_dbz    = dbz_r;
  assign busy            = (state != IDLE);
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed self-checking bench for div_sequencer (XLEN=64).
// Signed vectors are exercised when DIV_SIGNED_EN is defined; otherwise a
// signed-encoded op is checked to behave as unsigned.
module tb_div_sequencer;
  import div_pkg::*;

  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   n_cmp = 0;
  int   n_err = 0;

  div_sequencer_if #(.XLEN(XLEN)) bus ();

  div_sequencer #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Issue one request and wait for its response. lat = edge count from accept
  // edge to the first edge at which resp_valid is seen high (200 = timeout).
  task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a, b,
                        input bit ack, output logic [XLEN-1:0] res,
                        output logic dbz, output int lat);
    int k = 0;
    @(negedge clk);
    while (!bus.req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    k = 0;
    while (!bus.resp_valid && k < 199) begin
      @(posedge clk);
      #1;
      k++;
    end
    lat = k + 1;
    res = bus.resp_result;
    dbz = bus.resp_dbz;
    if (ack) begin
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.resp_result !== 64'd0) begin n_err++; $display("FAIL reset_result got %h want 0", bus.resp_result); end
    n_cmp++; if (bus.resp_dbz !== 1'b0) begin n_err++; $display("FAIL reset_dbz got %b want 0", bus.resp_dbz); end
  endtask

  task automatic test_unsigned;
    logic [XLEN-1:0] r; logic z; int l;
    run_op(OP_DIVU, 64'd100, 64'd7, 1'b1, r, z, l);
    n_cmp++; if (r !== 64'd14) begin n_err++; $display("FAIL divu_100_7 got %h want 14", r); end
    n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL divu_100_7_dbz got %b want 0", z); end
    n_cmp++; if (l != 67) begin n_err++; $display("FAIL divu_latency got %0d want 67", l); end
    run_op(OP_REMU, 64'd100, 64'd7, 1'b1, r, z, l);
    n_cmp++; if (r !== 64'd2) begin n_err++; $display("FAIL remu_100_7 got %h want 2", r); end
    n_cmp++; if (l != 67) begin n_err++; $display("FAIL remu_latency got %0d want 67", l); end
  endtask

  task automatic test_div_by_zero;
    logic [XLEN-1:0] r; logic z; int l;
    run_op(OP_DIVU, 64'd5, 64'd0, 1'b1, r, z, l);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL divu_dbz got %h want all ones", r); end
    n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL divu_dbz_flag got %b want 1", z); end
    n_cmp++; if (l != 2) begin n_err++; $display("FAIL divu_dbz_latency got %0d want 2", l); end
    run_op(OP_REMU, 64'd5, 64'd0, 1'b1, r, z, l);
    n_cmp++; if (r !== 64'd5) begin n_err++; $display("FAIL remu_dbz got %h want 5", r); end
    n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL remu_dbz_flag got %b want 1", z); end
  endtask

  task automatic test_signed;
    logic [XLEN-1:0] r; logic z; int l;
`ifdef DIV_SIGNED_EN
    run_op(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, r, z, l);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL div_m7_2 got %h want -3", r); end
    run_op(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, r, z, l);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL rem_m7_2 got %h want -1", r); end
    run_op(OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, r, z, l);
    n_cmp++; if (r !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL div_ovf got %h want 8000000000000000", r); end
    n_cmp++; if (l != 2) begin n_err++; $display("FAIL div_ovf_latency got %0d want 2", l); end
    n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL div_ovf_dbz got %b want 0", z); end
    run_op(OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, r, z, l);
    n_cmp++; if (r !== 64'd0) begin n_err++; $display("FAIL rem_ovf got %h want 0", r); end
`else
    // Signed encoding treated as unsigned: 0xFFFF..F9 / 2.
    run_op(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, r, z, l);
    n_cmp++; if (r !== 64'h7FFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL div_as_unsigned got %h want 7ffffffffffffffc", r); end
    run_op(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, r, z, l);
    n_cmp++; if (r !== 64'd1) begin n_err++; $display("FAIL rem_as_unsigned got %h want 1", r); end
    n_cmp++; if (l != 67) begin n_err++; $display("FAIL rem_as_unsigned_latency got %0d want 67", l); end
`endif
  endtask

  task automatic test_take_path;
    logic [XLEN-1:0] r; logic z; int l;
    run_op(OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b1, r, z, l);
    n_cmp++; if (r !== 64'd1) begin n_err++; $display("FAIL take_quot got %h want 1", r); end
    run_op(OP_REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b1, r, z, l);
    n_cmp++; if (r !== 64'h7FFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL take_rem got %h want 7ffffffffffffffe", r); end
  endtask

  task automatic test_backpressure;
    logic [XLEN-1:0] r; logic z; int l;
    run_op(OP_DIVU, 64'd100, 64'd7, 1'b0, r, z, l);
    n_cmp++; if (r !== 64'd14) begin n_err++; $display("FAIL bp_first got %h want 14", r); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_result !== 64'd14 || bus.resp_dbz !== 1'b0 || bus.req_ready !== 1'b0)
        begin n_err++; $display("FAIL bp_hold cyc %0d got v=%b r=%h z=%b rdy=%b want v=1 r=14 z=0 rdy=0",
                                i, bus.resp_valid, bus.resp_result, bus.resp_dbz, bus.req_ready); end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL bp_release got rdy=%b v=%b busy=%b want 1 0 0", bus.req_ready, bus.resp_valid, busy); end
    run_op(OP_DIVU, 64'd1000, 64'd10, 1'b1, r, z, l);
    n_cmp++; if (r !== 64'd100) begin n_err++; $display("FAIL bp_second got %h want 100", r); end
  endtask

  task automatic test_reset_mid_run;
    logic [XLEN-1:0] r; logic z; int l;
    int seen = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_DIVU;
    bus.req_a     = 64'd100;
    bus.req_b     = 64'd7;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (31) @(posedge clk);   // PREP, then 30 RUN iterations
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      begin n_err++; $display("FAIL mid_reset got busy=%b v=%b rdy=%b want 0 0 1", busy, bus.resp_valid, bus.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL mid_no_resp got %0d valid cycles want 0", seen); end
    run_op(OP_REMU, 64'd100, 64'd7, 1'b1, r, z, l);
    n_cmp++; if (r !== 64'd2) begin n_err++; $display("FAIL mid_next got %h want 2", r); end
    n_cmp++; if (l != 67) begin n_err++; $display("FAIL mid_next_latency got %0d want 67", l); end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_unsigned;
    test_div_by_zero;
    test_signed;
    test_take_path;
    test_backpressure;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle restoring divider controller for the execute stage. It accepts RV64M DIV/DIVU/REM/REMU requests and drives a single 64-bit subtractor (difference plus borrow, borrow=1 when a<b) for one trial subtraction per cycle. It returns quotient or remainder over a valid/ready handshake. It sits beside the ALU and stalls the pipeline through `busy`.

## Interface
- `XLEN`, 64: operand and result width. The iteration count equals XLEN.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_op`  in  2  bit1 selects the result: 0 = quotient, 1 = remainder. Bit0: 1 = signed, 0 = unsigned.
- `req_a`  in  XLEN  dividend.
- `req_b`  in  XLEN  divisor.
- `resp_valid`  out  1  result valid; held until accepted.
- `resp_ready`  in  1  consumer accepts.
- `resp_result`  out  XLEN  quotient or remainder.
- `resp_dbz`  out  1  divisor was zero.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States are IDLE, PREP, RUN, FIX and DONE.
- **IDLE:** on `req_valid && req_ready`, latch the op and operands, then go to PREP.
- **PREP:**
  - If b==0: set result to all ones (quotient) or to a (remainder), set `resp_dbz`=1, go to DONE.
  - If the op is signed, a = 0x8000…0 and b = all ones: set result to a (quotient) or 0 (remainder), go to DONE.
  - Otherwise, for signed ops, replace a and b with their magnitudes and record the quotient sign (sign a XOR sign b) and remainder sign (sign a). Clear the remainder register R, load Q with |a|, clear the iteration counter, go to RUN.
- **RUN:** XLEN iterations, MSB first. Each iteration:
  - Form S = {R[XLEN-2:0], Q[XLEN-1]} and compute S − |b| on the subtractor.
  - take = R[XLEN-1] OR NOT borrow. R[XLEN-1] covers the 65th bit of the shifted value.
  - If take, R ← difference (mod 2^XLEN); otherwise R ← S.
  - Q ← {Q[XLEN-2:0], take}.
  - When the counter reaches XLEN−1, go to FIX.
- **FIX:** negate Q or R (two's complement) if the corresponding sign flag is set. Select the output by op bit1. Go to DONE.
- **DONE:** `resp_valid`=1 with `resp_result` and `resp_dbz` stable. When `resp_ready` is high, go to IDLE.

## Timing
- Reset values: state IDLE, `req_ready`=1, `busy`=0, `resp_valid`=0, `resp_result`=0, `resp_dbz`=0. Counter, R, Q and the sign flags are all 0.
- Call the accepting edge T0.
  - Normal path: PREP at T0+1, RUN at T0+2 through T0+XLEN+1, FIX at T0+XLEN+2, `resp_valid` high from T0+XLEN+3. For XLEN=64 that is 67 cycles.
  - Divide-by-zero and signed overflow: `resp_valid` high from T0+2.
- `resp_valid && resp_ready` on edge Tn: IDLE and `req_ready`=1 from Tn+1. There is no back-to-back acceptance in the DONE cycle.
- `resp_ready` high before `resp_valid` has no effect. Response outputs must not change while `resp_valid && !resp_ready`.
- `req_valid` outside IDLE is ignored. Requests are never dropped silently: the requester holds `req_valid` until the handshake completes.
- Reset mid-operation: all state returns to reset values immediately, with no response issued.
- The counter width is clog2(XLEN). It must not wrap inside RUN.

## Configuration
- `DIV_SIGNED_EN`
  - Defined: signed ops are handled as described (magnitude conversion, overflow case, FIX negation).
  - Undefined: `req_op[0]` is ignored and every op is treated as unsigned. The overflow check and negation logic are not built, but the FIX state still exists, so latency is unchanged.

## Structure
- Package `div_pkg` holds the state enum, the `req_op` encodings (DIVU=2'b00, DIV=2'b01, REMU=2'b10, REM=2'b11) and the default XLEN constant.
- One sub-module: the team's existing 64-bit subtractor, instantiated once with inputs S and |b|, outputs difference and borrow. There is no second subtractor. The PREP magnitude and FIX negation steps use a separate simple negate expression.

## Test plan
- DIVU a=100, b=7 → `resp_result`=14, `resp_dbz`=0, `resp_valid` rises exactly 67 cycles after accept. REMU with the same operands → 2.
- DIVU a=5, b=0 → 0xFFFF_FFFF_FFFF_FFFF with `resp_dbz`=1 after 2 cycles. REMU with the same operands → 5.
- With `DIV_SIGNED_EN`:
  - DIV −7/2 → 0xFFFF_FFFF_FFFF_FFFD (−3); REM −7/2 → 0xFFFF_FFFF_FFFF_FFFF (−1).
  - DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000 after 2 cycles.
- DIVU 0xFFFF_FFFF_FFFF_FFFF / 0x8000_0000_0000_0001 → quotient 1, remainder 0x7FFF_FFFF_FFFF_FFFE. This exercises the R[XLEN-1] take path.
- Backpressure: hold `resp_ready` low for 5 cycles in DONE → outputs stable and `req_ready`=0. Then raise it → IDLE the next cycle. A second request is accepted and its result is correct.
- Deassert `rst_n` at RUN iteration 30 → `busy`=0 and `resp_valid`=0 immediately. No response is produced, and the next request completes normally.
